// File: rtl/ic_fetch_pkg.sv
// ic_fetch_pkg: shared address/data types and helpers for the fetch front-end.
// Rev 1.0
`default_nettype none

package ic_fetch_pkg;

   localparam int SC_LADDR_W        = 32;
   localparam int IC_DATA_W         = 128;
   localparam int IC_FETCH_NENTRIES = 4;

   typedef logic [SC_LADDR_W-1:0] SC_laddr_type;
   typedef logic [IC_DATA_W-1:0]  I_ictocore_type;

   typedef struct packed {
      SC_laddr_type   pc;
      I_ictocore_type data;
   } I_fetch_type;

   // Align down to the block boundary, then step one block; wraps naturally.
   function automatic SC_laddr_type next_fetch_pc(input SC_laddr_type pc,
                                                  input int unsigned fetch_bytes);
      SC_laddr_type mask;
      mask = SC_laddr_type'(fetch_bytes - 1);
      return (pc & ~mask) + SC_laddr_type'(fetch_bytes);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ic_fetch_queue.sv
// ic_fetch_queue: circular buffer of {pc, data, filled} with alloc/fill/head pointers.
// Rev 1.0
`default_nettype none

module ic_fetch_queue
   import ic_fetch_pkg::*;
#(
   parameter int unsigned NENTRIES = IC_FETCH_NENTRIES,
   parameter int          CW       = $clog2(NENTRIES + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 alloc_en,
   input  logic [SC_LADDR_W-1:0] alloc_pc,
   input  logic                 fill_en,
   input  logic [IC_DATA_W-1:0] fill_data,
   input  logic                 drain_en,
   output logic [CW-1:0]        count,
   output logic [CW-1:0]        unfilled,
   output logic                 head_valid,
   output logic [SC_LADDR_W-1:0] head_pc,
   output logic [IC_DATA_W-1:0] head_data
);

   localparam int PW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;

   I_fetch_type         entry [NENTRIES];
   logic [NENTRIES-1:0] filled;
   logic [PW-1:0]       alloc_ptr;
   logic [PW-1:0]       fill_ptr;
   logic [PW-1:0]       head_ptr;
   logic                do_fill;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
      return (ptr == PW'(NENTRIES - 1)) ? '0 : ptr + PW'(1);
   endfunction

   // A response with nothing awaiting data is ignored rather than corrupting state.
   assign do_fill = fill_en && (unfilled != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filled    <= '0;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         count     <= '0;
         unfilled  <= '0;
      end else if (flush) begin
         filled    <= '0;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         count     <= '0;
         unfilled  <= '0;
      end else begin
         if (alloc_en) begin
            filled[alloc_ptr] <= 1'b0;
            alloc_ptr         <= bump(alloc_ptr);
         end
         if (do_fill) begin
            filled[fill_ptr] <= 1'b1;
            fill_ptr         <= bump(fill_ptr);
         end
         if (drain_en) begin
            head_ptr <= bump(head_ptr);
         end
         count    <= count + CW'(alloc_en) - CW'(drain_en);
         unfilled <= unfilled + CW'(alloc_en) - CW'(do_fill);
      end
   end

   // Payload storage needs no reset: the filled bits and count qualify it.
   always_ff @(posedge clk) begin
      if (alloc_en && !flush) begin
         entry[alloc_ptr].pc <= alloc_pc;
      end
      if (do_fill && !flush) begin
         entry[fill_ptr].data <= fill_data;
      end
   end

   assign head_valid = (count != '0) && filled[head_ptr];
   assign head_pc    = entry[head_ptr].pc;
   assign head_data  = entry[head_ptr].data;

endmodule

`default_nettype wire

// File: rtl/ic_fetch.sv
// ic_fetch: sequential PC generator, credit-bounded icache requests, in-order delivery to decode.
// Rev 1.0
`default_nettype none

module ic_fetch
   import ic_fetch_pkg::*;
#(
   parameter int unsigned             FETCH_BYTES = 16,
   parameter int unsigned             NENTRIES    = IC_FETCH_NENTRIES,
   parameter logic [SC_LADDR_W-1:0]   RESET_PC    = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  redirect_valid,
   input  logic [SC_LADDR_W-1:0] redirect_pc,
   output logic                  coretoic_valid,
   input  logic                  coretoic_retry,
   output logic [SC_LADDR_W-1:0] coretoic_pc,
   input  logic                  ictocore_valid,
   output logic                  ictocore_retry,
   input  logic [IC_DATA_W-1:0]  ictocore,
   output logic                  fetch_valid,
   input  logic                  fetch_retry,
   output logic [SC_LADDR_W-1:0] fetch_pc,
   output logic [IC_DATA_W-1:0]  fetch_data
);

   localparam int CW = $clog2(NENTRIES + 1);

   SC_laddr_type  req_pc;
   SC_laddr_type  req_pc_nxt;
   SC_laddr_type  redir_pc;
   SC_laddr_type  redir_pc_nxt;
   logic          stale;
   logic          stale_nxt;
   logic [CW-1:0] squash_cnt;
   logic [CW-1:0] squash_nxt;

   logic [CW-1:0] count;
   logic [CW-1:0] unfilled;
   logic          head_valid;
   logic          credit_ok;
   logic          req_fire;
   logic          resp_drop;
   logic          resp_live;
   logic          alloc_en;
   logic          fill_en;
   logic          drain_en;
   logic          squash_req;

   assign credit_ok      = ({1'b0, count} + {1'b0, squash_cnt}) < (CW + 1)'(NENTRIES);
   assign coretoic_valid = reset && (stale || credit_ok);
   assign coretoic_pc    = req_pc;
   assign ictocore_retry = 1'b0;

   assign req_fire   = coretoic_valid && !coretoic_retry;
   assign resp_drop  = ictocore_valid && (squash_cnt != '0);
   assign resp_live  = ictocore_valid && (squash_cnt == '0);
   assign alloc_en   = req_fire && !stale && !redirect_valid;
   assign fill_en    = resp_live && !redirect_valid;
   // Wrong-path requests accepted by the icache get no queue slot; their response is owed.
   assign squash_req = req_fire && (stale || redirect_valid);

   assign fetch_valid = head_valid && !redirect_valid;
   assign drain_en    = fetch_valid && !fetch_retry;

   always_comb begin
      squash_nxt = squash_cnt;
      if (redirect_valid) begin
         // A live response this cycle lands on a flushed entry and pays one off.
         squash_nxt = squash_nxt + unfilled - CW'(resp_live);
      end
      squash_nxt = squash_nxt + CW'(squash_req) - CW'(resp_drop);
   end

   always_comb begin
      req_pc_nxt   = req_pc;
      redir_pc_nxt = redir_pc;
      stale_nxt    = stale;
      if (stale) begin
         if (req_fire) begin
            stale_nxt  = 1'b0;
            req_pc_nxt = redirect_valid ? redirect_pc : redir_pc;
         end else if (redirect_valid) begin
            redir_pc_nxt = redirect_pc;
         end
      end else if (redirect_valid) begin
         if (coretoic_valid && coretoic_retry) begin
            stale_nxt    = 1'b1;
            redir_pc_nxt = redirect_pc;
         end else begin
            req_pc_nxt = redirect_pc;
         end
      end else if (req_fire) begin
         req_pc_nxt = next_fetch_pc(req_pc, FETCH_BYTES);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_pc     <= RESET_PC;
         redir_pc   <= RESET_PC;
         stale      <= 1'b0;
         squash_cnt <= '0;
      end else begin
         req_pc     <= req_pc_nxt;
         redir_pc   <= redir_pc_nxt;
         stale      <= stale_nxt;
         squash_cnt <= squash_nxt;
      end
   end

   ic_fetch_queue #(
      .NENTRIES (NENTRIES),
      .CW       (CW)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_valid),
      .alloc_en   (alloc_en),
      .alloc_pc   (req_pc),
      .fill_en    (fill_en),
      .fill_data  (ictocore),
      .drain_en   (drain_en),
      .count      (count),
      .unfilled   (unfilled),
      .head_valid (head_valid),
      .head_pc    (fetch_pc),
      .head_data  (fetch_data)
   );

endmodule

`default_nettype wire

// File: tb/tb_ic_fetch.sv
// tb_ic_fetch: directed self-checking bench for ic_fetch.
// Rev 1.0
`default_nettype none

module tb_ic_fetch;

   logic         clk;
   logic         reset;
   logic         redirect_valid;
   logic [31:0]  redirect_pc;
   logic         coretoic_valid;
   logic         coretoic_retry;
   logic [31:0]  coretoic_pc;
   logic         ictocore_valid;
   logic         ictocore_retry;
   logic [127:0] ictocore;
   logic         fetch_valid;
   logic         fetch_retry;
   logic [31:0]  fetch_pc;
   logic [127:0] fetch_data;

   int total = 0;
   int bad   = 0;

   ic_fetch #(
      .FETCH_BYTES (16),
      .NENTRIES    (4),
      .RESET_PC    (32'h0000_0100)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .coretoic_valid (coretoic_valid),
      .coretoic_retry (coretoic_retry),
      .coretoic_pc    (coretoic_pc),
      .ictocore_valid (ictocore_valid),
      .ictocore_retry (ictocore_retry),
      .ictocore       (ictocore),
      .fetch_valid    (fetch_valid),
      .fetch_retry    (fetch_retry),
      .fetch_pc       (fetch_pc),
      .fetch_data     (fetch_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] blk(input logic [31:0] pc);
      return {pc ^ 32'hA5A5_0000, pc, ~pc, pc + 32'h1};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic resp(input logic [31:0] pc);
      ictocore_valid = 1'b1;
      ictocore       = blk(pc);
      cyc();
      ictocore_valid = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      coretoic_retry = 1'b0;
      ictocore_valid = 1'b0;
      ictocore       = '0;
      fetch_retry    = 1'b0;
      repeat (3) cyc();
      check("rst_cvalid", coretoic_valid, 0);
      check("rst_fvalid", fetch_valid, 0);
      check("rst_icretry", ictocore_retry, 0);

      // Sequential requests up to the credit limit.
      reset = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("seq_valid", coretoic_valid, 1);
         check("seq_pc", coretoic_pc, 32'h100 + 32'(16 * i));
         cyc();
      end
      check("full_cvalid", coretoic_valid, 0);
      cyc();
      check("full_cvalid2", coretoic_valid, 0);

      // Fill all four while decode stalls; head must hold.
      fetch_retry = 1'b1;
      for (int i = 0; i < 4; i++) resp(32'h100 + 32'(16 * i));
      for (int k = 0; k < 5; k++) begin
         check("stall_fvalid", fetch_valid, 1);
         check("stall_pc", fetch_pc, 32'h100);
         cyc();
      end
      coretoic_retry = 1'b1;
      fetch_retry    = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("drain_fvalid", fetch_valid, 1);
         check("drain_pc", fetch_pc, 32'h100 + 32'(16 * i));
         check("drain_data", fetch_data, blk(32'h100 + 32'(16 * i)));
         cyc();
      end
      check("drained_fvalid", fetch_valid, 0);
      check("reassert_cvalid", coretoic_valid, 1);
      check("reassert_pc", coretoic_pc, 32'h140);

      // Redirect while the request is retried: stale request held, then squashed.
      fetch_retry    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3000;
      cyc();
      redirect_valid = 1'b0;
      #1;
      check("stale_pc", coretoic_pc, 32'h140);
      check("stale_valid", coretoic_valid, 1);
      cyc();
      check("stale_pc2", coretoic_pc, 32'h140);
      coretoic_retry = 1'b0;
      cyc();
      check("stale_squash", dut.squash_cnt, 1);
      check("stale_tgt_pc", coretoic_pc, 32'h3000);
      cyc();
      check("stale_next_pc", coretoic_pc, 32'h3010);
      cyc();
      coretoic_retry = 1'b1;
      check("stale_next_pc2", coretoic_pc, 32'h3020);
      resp(32'h140);
      check("stale_drop_sq", dut.squash_cnt, 0);
      check("stale_drop_fv", fetch_valid, 0);
      resp(32'h3000);
      check("stale_first_fv", fetch_valid, 1);
      check("stale_first_pc", fetch_pc, 32'h3000);

      // Redirect coinciding with a response, two entries unfilled.
      coretoic_retry = 1'b0;
      cyc();
      cyc();
      check("p4_full_cvalid", coretoic_valid, 0);
      resp(32'h3010);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h4000;
      ictocore_valid = 1'b1;
      ictocore       = blk(32'h3020);
      #1;
      check("redir_fv_forced", fetch_valid, 0);
      cyc();
      redirect_valid = 1'b0;
      ictocore_valid = 1'b0;
      #1;
      check("p4_squash", dut.squash_cnt, 1);
      check("p4_pc", coretoic_pc, 32'h4000);
      cyc();
      coretoic_retry = 1'b1;
      check("p4_next_pc", coretoic_pc, 32'h4010);
      resp(32'h3030);
      check("p4_drop_sq", dut.squash_cnt, 0);
      check("p4_drop_fv", fetch_valid, 0);
      resp(32'h4000);
      check("p4_fv", fetch_valid, 1);
      check("p4_fpc", fetch_pc, 32'h4000);
      check("p4_fdata", fetch_data, blk(32'h4000));

      // Three outstanding, redirect to an unaligned target.
      coretoic_retry = 1'b0;
      repeat (3) cyc();
      check("p3_full_cvalid", coretoic_valid, 0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h2004;
      cyc();
      redirect_valid = 1'b0;
      #1;
      check("p3_squash", dut.squash_cnt, 3);
      check("p3_fv", fetch_valid, 0);
      check("p3_cvalid", coretoic_valid, 1);
      check("p3_pc", coretoic_pc, 32'h2004);
      cyc();
      check("p3_credit_stop", coretoic_valid, 0);
      resp(32'h4010);
      check("p3_sq2", dut.squash_cnt, 2);
      check("p3_next_valid", coretoic_valid, 1);
      check("p3_next_pc", coretoic_pc, 32'h2010);
      coretoic_retry = 1'b1;
      resp(32'h4020);
      resp(32'h4030);
      check("p3_sq0", dut.squash_cnt, 0);
      check("p3_drop_fv", fetch_valid, 0);
      resp(32'h2004);
      check("p3_first_fv", fetch_valid, 1);
      check("p3_first_pc", fetch_pc, 32'h2004);

      // Wrap at the top of the address space; redirect-cycle accept is squashed.
      coretoic_retry = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF0;
      cyc();
      redirect_valid = 1'b0;
      #1;
      check("wrap_squash", dut.squash_cnt, 1);
      check("wrap_pc", coretoic_pc, 32'hFFFF_FFF0);
      cyc();
      coretoic_retry = 1'b1;
      check("wrap_next_pc", coretoic_pc, 32'h0);
      resp(32'h2010);
      resp(32'hFFFF_FFF0);
      check("wrap_fv", fetch_valid, 1);
      check("wrap_fpc", fetch_pc, 32'hFFFF_FFF0);

      // Asynchronous reset mid-stream.
      reset = 1'b0;
      #1;
      check("async_rst_fv", fetch_valid, 0);
      check("async_rst_cv", coretoic_valid, 0);
      check("async_rst_icr", ictocore_retry, 0);
      cyc();
      reset = 1'b1;
      #1;
      check("post_rst_cv", coretoic_valid, 1);
      check("post_rst_pc", coretoic_pc, 32'h100);
      check("post_rst_sq", dut.squash_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
